// File: rtl/vram_tile_injector.sv
// Buffers one complete 2bpp tile from the glyph path, then writes it into VRAM tile data one byte per free bus slot.
// Optional build macro VRAM_INJECT_COLLISION_EN: a CPU write into the target tile during WRITE restarts the tile.
module vram_tile_injector #(
    parameter int unsigned TILE_SIZE_BYTES = 16,
    parameter logic [12:0] VRAM_TILE_START = 13'h0000,
    parameter logic [12:0] VRAM_TILE_END   = 13'h17FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic [8:0]  in_tile_index,
    input  logic        vram_slot,
    input  logic        cpu_vram_we,
    input  logic [12:0] cpu_vram_addr,
    output logic        vram_we,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        inject_busy,
    output logic        inject_done,
    output logic        inject_error,
    output logic        inject_collision
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_WRITE, S_DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(TILE_SIZE_BYTES - 1);

    state_t      state_q;
    logic [7:0]  buf_q [TILE_SIZE_BYTES];
    logic [3:0]  count_q;
    logic [3:0]  offset_q;
    logic [12:0] base_q;
    logic        error_q;
    logic        collision_q;

    logic        accept;
    logic        hit_tile;
    logic        out_of_region;
    logic [12:0] base_d;

    assign base_d        = VRAM_TILE_START + {in_tile_index, 4'b0000};
    // 14-bit compare so a tile straddling the top of the 13-bit space is still caught
    assign out_of_region = ({1'b0, base_d} + 14'd15) > {1'b0, VRAM_TILE_END};

    assign in_ready = cfg_enable && !rst &&
                      (state_q == S_IDLE || state_q == S_LOAD || state_q == S_DRAIN);
    assign accept   = in_valid && in_ready;

    assign vram_we    = (state_q == S_WRITE) && vram_slot && !cpu_vram_we;
    assign vram_addr  = vram_we ? (base_q + {9'b0, offset_q}) : 13'h0000;
    assign vram_wdata = vram_we ? buf_q[offset_q] : 8'h00;

    assign inject_busy  = (state_q != S_IDLE);
    assign inject_done  = (state_q == S_DONE);
    assign inject_error = error_q;

`ifdef VRAM_INJECT_COLLISION_EN
    assign hit_tile         = cpu_vram_we && (cpu_vram_addr[12:4] == base_q[12:4]);
    assign inject_collision = collision_q;
`else
    logic unused_collision;
    assign hit_tile         = 1'b0;
    assign inject_collision = 1'b0;
    assign unused_collision = ^{cpu_vram_addr, collision_q};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= 4'd0;
            offset_q    <= 4'd0;
            base_q      <= 13'h0000;
            error_q     <= 1'b0;
            collision_q <= 1'b0;
            for (int i = 0; i < TILE_SIZE_BYTES; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            error_q     <= 1'b0;
            collision_q <= 1'b0;
            if (!cfg_enable) begin
                state_q  <= S_IDLE;
                count_q  <= 4'd0;
                offset_q <= 4'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            buf_q[0] <= in_data;
                            base_q   <= base_d;
                            count_q  <= 4'd1;
                            offset_q <= 4'd0;
                            if (in_last) begin
                                error_q <= 1'b1;
                            end else if (out_of_region) begin
                                state_q <= S_DRAIN;
                            end else begin
                                state_q <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (accept) begin
                            buf_q[count_q] <= in_data;
                            count_q        <= count_q + 4'd1;
                            if (count_q == LAST_IDX) begin
                                state_q  <= in_last ? S_WRITE : S_DRAIN;
                                offset_q <= 4'd0;
                            end else if (in_last) begin
                                error_q <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (accept && in_last) begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    S_WRITE: begin
                        // The game overwrote the target tile, so start the tile over
                        if (hit_tile) begin
                            offset_q    <= 4'd0;
                            collision_q <= 1'b1;
                        end else if (vram_we) begin
                            offset_q <= offset_q + 4'd1;
                            if (offset_q == LAST_IDX) begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vram_tile_injector.sv
// Directed bench for vram_tile_injector: table of tile streams with expected write/pulse counts and timing.
module tb_vram_tile_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [8:0]  in_tile_index;
    logic        vram_slot;
    logic        cpu_vram_we;
    logic [12:0] cpu_vram_addr;
    logic        vram_we;
    logic [12:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        inject_busy;
    logic        inject_done;
    logic        inject_error;
    logic        inject_collision;

    vram_tile_injector dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_enable       (cfg_enable),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_tile_index    (in_tile_index),
        .vram_slot        (vram_slot),
        .cpu_vram_we      (cpu_vram_we),
        .cpu_vram_addr    (cpu_vram_addr),
        .vram_we          (vram_we),
        .vram_addr        (vram_addr),
        .vram_wdata       (vram_wdata),
        .inject_busy      (inject_busy),
        .inject_done      (inject_done),
        .inject_error     (inject_error),
        .inject_collision (inject_collision)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {5'b0, in_ready, vram_we, vram_addr, vram_wdata,
                inject_busy, inject_done, inject_error, inject_collision};
    endfunction

    // Write monitor: every injector write must hit base+offset with the matching buffered byte
    logic        mon_on = 1'b0;
    logic [12:0] mon_base;
    logic [7:0]  mon_data [16];
    logic [3:0]  mon_off;
    int          n_wr, n_done, n_errp, n_col;

    always @(negedge clk) begin
        if (mon_on) begin
            if (inject_collision) begin
                n_col++;
                mon_off = 4'd0;
            end
            if (inject_done)  n_done++;
            if (inject_error) n_errp++;
            if (cpu_vram_we) chk("we_with_cpu_write", 32'(vram_we), 32'd0);
            if (vram_we) begin
                chk("wr_addr", 32'(vram_addr), 32'(mon_base + {9'b0, mon_off}));
                chk("wr_data", 32'(vram_wdata), 32'(mon_data[mon_off]));
                mon_off = mon_off + 4'd1;
                n_wr++;
            end else begin
                chk("idle_bus_zero", {11'b0, vram_addr, vram_wdata}, 32'd0);
            end
        end
    end

    typedef struct {
        string       name;
        logic [8:0]  idx;
        int          nbytes;
        logic [7:0]  seed;
        int          mode;      // 0: slot always granted, 1: slot on odd cycles only
        int          cpu_k;     // post-stream cycle carrying a CPU write (0 = none)
        logic [12:0] cpu_addr;
        int          off_k;     // post-stream cycle with cfg_enable low (0 = none)
        int          exp_wr;
        int          exp_err;
        int          exp_done;
        int          exp_col;
        int          exp_k;     // cycle of first done/error pulse after last accept (0 = none)
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input vec_t v);
        int first_k;
        int rdy1;
        int miss;
        mon_base = {v.idx, 4'b0000};
        for (int i = 0; i < 16; i++) mon_data[i] = v.seed + 8'(i);
        mon_off = 4'd0;
        n_wr = 0; n_done = 0; n_errp = 0; n_col = 0;
        mon_on = 1'b1;
        miss = 0;
        first_k = 0;
        rdy1 = 0;
        cfg_enable = 1'b1;
        vram_slot = 1'b1;
        for (int i = 0; i < v.nbytes; i++) begin
            in_valid      = 1'b1;
            in_data       = v.seed + 8'(i);
            in_last       = (i == v.nbytes - 1);
            in_tile_index = (i == 0) ? v.idx : 9'h1AA;
            @(negedge clk);
            if (!in_ready) miss++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            vram_slot     = (v.mode == 0) ? 1'b1 : 1'(k % 2);
            cpu_vram_we   = (k == v.cpu_k);
            cpu_vram_addr = (k == v.cpu_k) ? v.cpu_addr : 13'h0000;
            cfg_enable    = (k != v.off_k);
            if (k == v.off_k) vram_slot = 1'b0;
            @(negedge clk);
            if (k == 1) rdy1 = int'(in_ready);
            if (first_k == 0 && (inject_done || inject_error)) first_k = k;
            @(posedge clk); #1;
        end
        cpu_vram_we = 1'b0;
        mon_on = 1'b0;
        chk({v.name, ":ready_during_stream"}, 32'(miss), 32'd0);
        chk({v.name, ":writes"},    32'(n_wr),   32'(v.exp_wr));
        chk({v.name, ":errors"},    32'(n_errp), 32'(v.exp_err));
        chk({v.name, ":done"},      32'(n_done), 32'(v.exp_done));
        chk({v.name, ":collision"}, 32'(n_col),  32'(v.exp_col));
        chk({v.name, ":pulse_cycle"}, 32'(first_k), 32'(v.exp_k));
        chk({v.name, ":ready_k1"},  32'(rdy1), (v.exp_wr == 0) ? 32'd1 : 32'd0);
        chk({v.name, ":busy_end"},  32'(inject_busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"nominal",   9'd5,   16, 8'h10, 0, 0,  13'h0000, 0, 16, 0, 1, 0, 17};
        vecs[1] = '{"short",     9'd7,    8, 8'h20, 0, 0,  13'h0000, 0,  0, 1, 0, 0,  1};
        vecs[2] = '{"long",      9'd2,   20, 8'h30, 0, 0,  13'h0000, 0,  0, 1, 0, 0,  1};
        vecs[3] = '{"bad_index", 9'd384, 16, 8'h40, 0, 0,  13'h0000, 0,  0, 1, 0, 0,  1};
        vecs[4] = '{"stalls",    9'd5,   16, 8'h50, 1, 5,  13'h1000, 0, 16, 0, 1, 0, 34};
        vecs[5] = '{"last_tile", 9'd383, 16, 8'h60, 1, 0,  13'h0000, 0, 16, 0, 1, 0, 32};
        vecs[6] = '{"single",    9'd1,    1, 8'h70, 0, 0,  13'h0000, 0,  0, 1, 0, 0,  1};
        vecs[7] = '{"bad_single",9'd511,  1, 8'h78, 0, 0,  13'h0000, 0,  0, 1, 0, 0,  1};
`ifdef VRAM_INJECT_COLLISION_EN
        vecs[8] = '{"collision", 9'd5,   16, 8'h80, 0, 10, 13'h0053, 0, 25, 0, 1, 1, 27};
`else
        vecs[8] = '{"collision", 9'd5,   16, 8'h80, 0, 10, 13'h0053, 0, 16, 0, 1, 0, 18};
`endif
        vecs[9] = '{"abort",     9'd5,   16, 8'h90, 0, 0,  13'h0000, 5,  4, 0, 0, 0,  0};

        rst = 1'b1;
        cfg_enable = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        in_tile_index = 9'd0;
        vram_slot = 1'b1;
        cpu_vram_we = 1'b0;
        cpu_vram_addr = 13'h0000;

        #12;
        chk("reset_outputs", all_outs(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of LOAD: outputs clear at once, next tile starts clean
        for (int i = 0; i < 5; i++) begin
            in_valid      = 1'b1;
            in_data       = 8'hA0 + 8'(i);
            in_last       = 1'b0;
            in_tile_index = 9'd5;
            @(posedge clk); #1;
        end
        chk("busy_in_load", 32'(inject_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("reset_mid_load", all_outs(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
